// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// controller states and the default RAM depth.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_WORDS_DEFAULT = 4096;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_EXTRACT = 3'd2,
        S_WRITE   = 3'd3,
        S_MERGE   = 3'd4
    } lsuState_t;

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: little-endian byte/halfword extraction with
// sign/zero extension, store-lane merging and alignment checking.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addrLow,
    input  logic [2:0]  funct3,
    input  logic [31:0] storeData,
    output logic [31:0] loadValue,
    output logic [31:0] mergedWord,
    output logic        misaligned
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = 8'h00;
        case (addrLow)
            2'd0:    byteVal = word[7:0];
            2'd1:    byteVal = word[15:8];
            2'd2:    byteVal = word[23:16];
            default: byteVal = word[31:24];
        endcase
        halfVal = addrLow[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        loadValue = 32'h0;
        case (funct3)
            F3_B:    loadValue = {{24{byteVal[7]}}, byteVal};
            F3_H:    loadValue = {{16{halfVal[15]}}, halfVal};
            F3_W:    loadValue = word;
            F3_BU:   loadValue = {24'h0, byteVal};
            F3_HU:   loadValue = {16'h0, halfVal};
            default: loadValue = 32'h0;
        endcase
    end

    // Only the addressed lane(s) change; the rest of the word is the RAM read-back.
    always_comb begin
        mergedWord = word;
        case (funct3)
            F3_B: begin
                case (addrLow)
                    2'd0:    mergedWord[7:0]   = storeData[7:0];
                    2'd1:    mergedWord[15:8]  = storeData[7:0];
                    2'd2:    mergedWord[23:16] = storeData[7:0];
                    default: mergedWord[31:24] = storeData[7:0];
                endcase
            end
            F3_H: begin
                if (addrLow[1]) mergedWord[31:16] = storeData[15:0];
                else            mergedWord[15:0]  = storeData[15:0];
            end
            F3_W:    mergedWord = storeData;
            default: mergedWord = word;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if (funct3[1:0] == 2'b01)      misaligned = addrLow[0];
        else if (funct3[1:0] == 2'b10) misaligned = (addrLow != 2'b00);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide synchronous RAM with
// 1-cycle read latency; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqStoreData,
    output logic        respValid,
    output logic        respError,
    output logic [31:0] loadData,
    output logic [31:0] ramAddress,
    output logic [31:0] ramDataIn,
    output logic        ramWriteEnable,
    input  logic [31:0] ramDataOut
);

    lsuState_t   state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] data_q;
    logic        write_q;
    logic        respValid_q, respValid_d;
    logic        respError_q, respError_d;
    logic [31:0] loadData_q, loadData_d;

    logic        accept;
    logic        funct3Legal;
    logic        outOfRange;
    logic        reqError;
    logic [1:0]  laneAddr;
    logic [2:0]  laneFunct3;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;
    logic        misaligned;

    assign reqReady = (state_q == S_IDLE);
    assign accept   = reqValid && reqReady;

    // In IDLE the lane unit checks the incoming request's alignment;
    // in every other state it works on the latched request.
    assign laneAddr   = reqReady ? reqAddress[1:0] : addr_q[1:0];
    assign laneFunct3 = reqReady ? reqFunct3 : funct3_q;

    lsu_lane_unit u_lane (
        .word       (ramDataOut),
        .addrLow    (laneAddr),
        .funct3     (laneFunct3),
        .storeData  (data_q),
        .loadValue  (loadValue),
        .mergedWord (mergedWord),
        .misaligned (misaligned)
    );

    always_comb begin
        funct3Legal = 1'b0;
        case (reqFunct3)
            F3_B, F3_H, F3_W: funct3Legal = 1'b1;
            F3_BU, F3_HU:     funct3Legal = !reqWrite;
            default:          funct3Legal = 1'b0;
        endcase
        outOfRange = ({2'b00, reqAddress[31:2]} >= 32'(MEM_WORDS));
        reqError   = !funct3Legal || misaligned || outOfRange;
    end

    always_comb begin
        state_d     = state_q;
        respValid_d = 1'b0;
        respError_d = 1'b0;
        loadData_d  = loadData_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reqError) begin
                        respValid_d = 1'b1;
                        respError_d = 1'b1;
                        loadData_d  = 32'h0;
                    end else if (reqWrite && reqFunct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = write_q ? S_MERGE : S_EXTRACT;
            S_EXTRACT: begin
                state_d     = S_IDLE;
                respValid_d = 1'b1;
                loadData_d  = loadValue;
            end
            S_WRITE, S_MERGE: begin
                state_d     = S_IDLE;
                respValid_d = 1'b1;
                loadData_d  = 32'h0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            respValid_q <= 1'b0;
            respError_q <= 1'b0;
            loadData_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            respValid_q <= respValid_d;
            respError_q <= respError_d;
            loadData_q  <= loadData_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            data_q   <= 32'h0;
            write_q  <= 1'b0;
        end else if (accept) begin
            addr_q   <= reqAddress;
            funct3_q <= reqFunct3;
            data_q   <= reqStoreData;
            write_q  <= reqWrite;
        end
    end

    // Write strobe comes straight from the state so an async reset kills it at once.
    assign ramWriteEnable = (state_q == S_WRITE) || (state_q == S_MERGE);
    assign ramDataIn      = (state_q == S_MERGE) ? mergedWord : data_q;
    assign ramAddress     = {addr_q[31:2], 2'b00};
    assign respValid      = respValid_q;
    assign respError      = respError_q;
    assign loadData       = loadData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 1-cycle-latency word RAM.
module tb_load_store_unit;

    logic        clk;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddress;
    logic [31:0] reqStoreData;
    logic        respValid;
    logic        respError;
    logic [31:0] loadData;
    logic [31:0] ramAddress;
    logic [31:0] ramDataIn;
    logic        ramWriteEnable;
    logic [31:0] ramDataOut;

    logic [31:0] mem [0:4095];
    logic        preloadEn;
    logic [11:0] preloadIdx;
    logic [31:0] preloadVal;
    int          weCount;
    int          total;
    int          bad;

    load_store_unit #(.MEM_WORDS(4096)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqFunct3      (reqFunct3),
        .reqAddress     (reqAddress),
        .reqStoreData   (reqStoreData),
        .respValid      (respValid),
        .respError      (respError),
        .loadData       (loadData),
        .ramAddress     (ramAddress),
        .ramDataIn      (ramDataIn),
        .ramWriteEnable (ramWriteEnable),
        .ramDataOut     (ramDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM; the preload port lets the bench seed words during reset.
    always @(posedge clk) begin
        if (preloadEn) begin
            mem[preloadIdx] <= preloadVal;
        end else if (ramWriteEnable === 1'b1) begin
            mem[ramAddress[13:2]] <= ramDataIn;
        end
        ramDataOut <= mem[ramAddress[13:2]];
        if (ramWriteEnable === 1'b1) weCount++;
    end

    // Issues one request and reports how many edges (accept edge = 1) it took
    // until respValid was seen, along with the response fields.
    task automatic applyStimulus(input logic w, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 output int edges, output logic err,
                                 output logic [31:0] ld);
        @(negedge clk);
        reqValid     = 1'b1;
        reqWrite     = w;
        reqFunct3    = f3;
        reqAddress   = addr;
        reqStoreData = data;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        edges    = 1;
        while (respValid !== 1'b1 && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        err = respError;
        ld  = loadData;
    endtask

    task automatic test_reset();
        resetN       = 1'b0;
        reqValid     = 1'b0;
        reqWrite     = 1'b0;
        reqFunct3    = 3'b000;
        reqAddress   = 32'h0;
        reqStoreData = 32'h0;
        preloadEn    = 1'b1;
        preloadIdx   = 12'h040;
        preloadVal   = 32'h0000_0000;
        @(posedge clk);
        #1;
        preloadIdx = 12'h041;
        preloadVal = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        preloadEn = 1'b0;
        total++;
        if (respValid !== 1'b0 || respError !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_resp: got valid=%b err=%b expected 0 0", respValid, respError);
        end
        total++;
        if (loadData !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_loadData: got %h expected 00000000", loadData);
        end
        total++;
        if (ramWriteEnable !== 1'b0 || ramAddress !== 32'h0 || reqReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ram: got we=%b addr=%h ready=%b expected 0 00000000 1",
                     ramWriteEnable, ramAddress, reqReady);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_store_word();
        int edges; logic err; logic [31:0] ld; int weBefore;
        weBefore = weCount;
        applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, edges, err, ld);
        total++;
        if (edges !== 2 || err !== 1'b0 || ld !== 32'h0) begin
            bad++;
            $display("[TB] FAIL sw_resp: got edges=%0d err=%b ld=%h expected 2 0 00000000", edges, err, ld);
        end
        total++;
        if (weCount - weBefore !== 1) begin
            bad++;
            $display("[TB] FAIL sw_we_cycles: got %0d expected 1", weCount - weBefore);
        end
        total++;
        if (mem[12'h040] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL sw_mem: got %h expected deadbeef", mem[12'h040]);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b010};
        logic [31:0] adrs [3] = '{32'h103, 32'h102, 32'h100};
        logic [31:0] exps [3] = '{32'hFFFF_FFDE, 32'h0000_00AD, 32'hDEAD_BEEF};
        int edges; logic err; logic [31:0] ld; int weBefore;
        weBefore = weCount;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, f3s[i], adrs[i], 32'h0, edges, err, ld);
            total++;
            if (edges !== 3 || err !== 1'b0 || ld !== exps[i]) begin
                bad++;
                $display("[TB] FAIL load_%0d: got edges=%0d err=%b data=%h expected 3 0 %h",
                         i, edges, err, ld, exps[i]);
            end
        end
        total++;
        if (weCount !== weBefore) begin
            bad++;
            $display("[TB] FAIL load_no_write: got %0d writes expected 0", weCount - weBefore);
        end
    endtask

    task automatic test_rmw();
        int edges; logic err; logic [31:0] ld; int weBefore;
        weBefore = weCount;
        applyStimulus(1'b1, 3'b001, 32'h102, 32'hFFFF_1234, edges, err, ld);
        total++;
        if (edges !== 3 || err !== 1'b0 || mem[12'h040] !== 32'h1234_BEEF) begin
            bad++;
            $display("[TB] FAIL sh_rmw: got edges=%0d err=%b mem=%h expected 3 0 1234beef",
                     edges, err, mem[12'h040]);
        end
        applyStimulus(1'b1, 3'b000, 32'h100, 32'h0000_0077, edges, err, ld);
        total++;
        if (edges !== 3 || err !== 1'b0 || mem[12'h040] !== 32'h1234_BE77) begin
            bad++;
            $display("[TB] FAIL sb_rmw: got edges=%0d err=%b mem=%h expected 3 0 1234be77",
                     edges, err, mem[12'h040]);
        end
        total++;
        if (weCount - weBefore !== 2) begin
            bad++;
            $display("[TB] FAIL rmw_we_cycles: got %0d expected 2", weCount - weBefore);
        end
        applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, edges, err, ld);
        total++;
        if (edges !== 3 || err !== 1'b0 || ld !== 32'h0000_1234) begin
            bad++;
            $display("[TB] FAIL lh_after_rmw: got edges=%0d err=%b data=%h expected 3 0 00001234",
                     edges, err, ld);
        end
    endtask

    task automatic test_errors();
        logic        ws   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s  [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
        logic [31:0] adrs [4] = '{32'h101, 32'h102, 32'h100, 32'h4000};
        int edges; logic err; logic [31:0] ld; int weBefore;
        for (int i = 0; i < 4; i++) begin
            weBefore = weCount;
            applyStimulus(ws[i], f3s[i], adrs[i], 32'h5555_AAAA, edges, err, ld);
            total++;
            if (edges !== 1 || err !== 1'b1 || ld !== 32'h0 || weCount !== weBefore) begin
                bad++;
                $display("[TB] FAIL error_%0d: got edges=%0d err=%b data=%h writes=%0d expected 1 1 00000000 0",
                         i, edges, err, ld, weCount - weBefore);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (respValid !== 1'b0 || respError !== 1'b0 || reqReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL error_pulse: got valid=%b err=%b ready=%b expected 0 0 1",
                     respValid, respError, reqReady);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        reqValid     = 1'b1;
        reqWrite     = 1'b0;
        reqFunct3    = 3'b010;
        reqAddress   = 32'h100;
        reqStoreData = 32'h0;
        @(posedge clk);
        #1;
        reqAddress = 32'h104;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (respValid !== 1'b1 || reqReady !== 1'b1 || loadData !== 32'h1234_BE77) begin
            bad++;
            $display("[TB] FAIL b2b_first: got valid=%b ready=%b data=%h expected 1 1 1234be77",
                     respValid, reqReady, loadData);
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        total++;
        if (respValid !== 1'b0 || reqReady !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_accept: got valid=%b ready=%b expected 0 0", respValid, reqReady);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (respValid !== 1'b1 || respError !== 1'b0 || loadData !== 32'hCAFE_F00D) begin
            bad++;
            $display("[TB] FAIL b2b_second: got valid=%b err=%b data=%h expected 1 0 cafef00d",
                     respValid, respError, loadData);
        end
    endtask

    task automatic test_reset_mid_merge();
        int weBefore;
        weBefore = weCount;
        @(negedge clk);
        reqValid     = 1'b1;
        reqWrite     = 1'b1;
        reqFunct3    = 3'b000;
        reqAddress   = 32'h100;
        reqStoreData = 32'h0000_00AA;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ramWriteEnable !== 1'b1) begin
            bad++;
            $display("[TB] FAIL merge_we: got %b expected 1", ramWriteEnable);
        end
        #2;
        resetN = 1'b0;
        #1;
        total++;
        if (ramWriteEnable !== 1'b0 || respValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_abort: got we=%b valid=%b expected 0 0", ramWriteEnable, respValid);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (mem[12'h040] !== 32'h1234_BE77 || weCount !== weBefore) begin
            bad++;
            $display("[TB] FAIL reset_mem: got mem=%h writes=%0d expected 1234be77 0",
                     mem[12'h040], weCount - weBefore);
        end
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (reqReady !== 1'b1 || respValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_recover: got ready=%b valid=%b expected 1 0", reqReady, respValid);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        weCount   = 0;
        preloadEn = 1'b0;
        test_reset();
        test_store_word();
        test_loads();
        test_rmw();
        test_errors();
        test_back_to_back();
        test_reset_mid_merge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
